// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for the 4-digit Basys seven-segment
//   display. Captures a 32-bit value into a snapshot on a load strobe and
//   shows one 16-bit page of it as four hex digits. A blanking gap with all
//   anodes off separates consecutive digits to prevent ghosting.
//
//   Optional build macro: SEG_LZB_EN -- leading-zero blanking per page.
//   Digit k is dark when it and every higher digit of the page are zero.
//   Digit 0 is always shown. Scan timing is identical either way.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   value_in     value to capture
//   value_valid  load strobe (snapshot <= value_in unless frozen)
//   freeze       1 = ignore value_valid, hold snapshot
//   page         0 = show snapshot[15:0], 1 = show snapshot[31:16]
//   an           anodes, active-low, one-hot-low while driving
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low (upper-page indicator on digit 0)
//   digit_idx    digit currently selected (0 = rightmost)
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int unsigned REFRESH_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES   = 1000,
   parameter int unsigned DW             = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] value_in,
   input  logic          value_valid,
   input  logic          freeze,
   input  logic          page,
   output logic [3:0]    an,
   output logic [6:0]    seg,
   output logic          dp,
   output logic [1:0]    digit_idx
);

   localparam int unsigned PW      = DW / 2;
   localparam int unsigned MAX_CYC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST   = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
   localparam bit            HAS_BLANK    = (BLANK_CYCLES != 0);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    idx_nxt;
   logic [DW-1:0] snapshot;

   logic [PW-1:0] page_val;
   logic [PW-1:0] page_shift;
   logic [3:0]    nib;
   logic          dark;

   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Snapshot capture; freeze masks the strobe, last strobe wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snapshot <= '0;
      end else if (value_valid && !freeze) begin
         snapshot <= value_in;
      end
   end

   // State, phase counter and digit index registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_BLANK;
         cnt       <= '0;
         digit_idx <= 2'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         digit_idx <= idx_nxt;
      end
   end

   // Next-state: BLANK -> DRIVE -> (advance digit) -> BLANK; skip BLANK when no gap
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      idx_nxt   = digit_idx;
      case (state)
         ST_BLANK: begin
            if (!HAS_BLANK || (cnt == BLANK_LAST)) begin
               state_nxt = ST_DRIVE;
               cnt_nxt   = '0;
            end
         end
         ST_DRIVE: begin
            if (cnt == REFRESH_LAST) begin
               idx_nxt   = digit_idx + 2'd1;
               cnt_nxt   = '0;
               state_nxt = HAS_BLANK ? ST_BLANK : ST_DRIVE;
            end
         end
         default: begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Digit selection for the upcoming cycle; page is live, not latched
   always_comb begin
      page_val   = page ? snapshot[DW-1:PW] : snapshot[PW-1:0];
      page_shift = page_val >> {idx_nxt, 2'b00};
      nib        = page_shift[3:0];
`ifdef SEG_LZB_EN
      // Dark when this digit and all higher ones are zero; digit 0 always lit
      dark       = (idx_nxt != 2'd0) && (page_shift == '0);
`else
      dark       = 1'b0;
`endif
   end

   // Output decode aligned with the next state so outputs track the registers
   always_comb begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'b1111111;
      dp_nxt  = 1'b1;
      if ((state_nxt == ST_DRIVE) && !dark) begin
         an_nxt  = ~(4'b0001 << idx_nxt);
         seg_nxt = hex7(nib);
         dp_nxt  = !((idx_nxt == 2'd0) && page);
      end
   end

   // Registered display outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule
